slicel_cfg_sequencer: RTL

Configuration sequencer for one `slicel` tile. It accepts the tile's configuration bitstream as a word stream with a valid/ready handshake and serializes it into the slice's config shift chain one bit per clock. It holds the slice in config mode (`cen`=1, `reg_ce`=0) while loading, then releases it to run mode (`cen`=0, `reg_ce`=1) after a settle window. It sits between the fabric-level bitstream loader and each `slicel` instance.

---
 rtl/slicel_cfg_pkg.sv | 23 ++
 rtl/slicel_cfg_ser.sv | 44 ++++
 rtl/slicel_cfg_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/slicel_cfg_pkg.sv
// rtl/slicel_cfg_pkg.sv - shared types, defaults and sizing helpers for the slicel config sequencer
package slicel_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_SETTLE,
    ST_RUN
  } state_t;

  localparam int CFG_BITS_DEF = 143;
  localparam int WORD_W_DEF   = 8;

  function automatic int calc_nw(input int cfg_bits, input int word_w);
    return (cfg_bits + word_w - 1) / word_w;
  endfunction

  function automatic int calc_pad(input int cfg_bits, input int word_w);
    return calc_nw(cfg_bits, word_w) * word_w - cfg_bits;
  endfunction

endpackage

// File: rtl/slicel_cfg_ser.sv
// rtl/slicel_cfg_ser.sv - parallel-load MSB-first word serializer with bit counter and last_bit flag
module slicel_cfg_ser
  import slicel_cfg_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int PAD    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              first,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              sout,
  output logic              last_bit
);

  localparam int CW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] sreg;
  logic [CW-1:0]     cnt;

  // Word 0 is pre-shifted so its padding bits never reach the MSB output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (clr) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= first ? (din << PAD) : din;
      cnt  <= first ? CW'(WORD_W - PAD) : CW'(WORD_W);
    end else if (shift && cnt != '0) begin
      sreg <= {sreg[WORD_W-2:0], 1'b0};
      cnt  <= cnt - 1'b1;
    end
  end

  assign sout     = sreg[WORD_W-1];
  assign last_bit = (cnt == CW'(1));

endmodule

// File: rtl/slicel_cfg_sequencer.sv
// rtl/slicel_cfg_sequencer.sv - slicel config loader: word stream to serial chain, then run mode
// Optional parity check of the shifted stream is enabled by defining SLICEL_CFG_PARITY_EN.
module slicel_cfg_sequencer
  import slicel_cfg_pkg::*;
#(
  parameter int CFG_BITS   = CFG_BITS_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_sin,
  output logic              cfg_shift_en,
  output logic              cen,
  output logic              reg_ce,
  output logic              busy,
  output logic              done
`ifdef SLICEL_CFG_PARITY_EN
  ,
  input  logic              cfg_parity,
  output logic              parity_err
`endif
);

  localparam int NW  = calc_nw(CFG_BITS, WORD_W);
  localparam int PAD = calc_pad(CFG_BITS, WORD_W);
  localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
  localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t         state, state_nxt;
  logic [WCW-1:0] wcnt;
  logic [SCW-1:0] scnt;
  logic           last_bit;
  logic           accept, word_end, settle_end, load_go, par_ok;

  assign accept     = (state == ST_LOAD) && word_valid;
  assign word_end   = (state == ST_SHIFT) && last_bit;
  assign settle_end = (state == ST_SETTLE) && (scnt == SCW'(SETTLE_CYC - 1));
  assign load_go    = start && ((state == ST_IDLE) || (state == ST_RUN));

  slicel_cfg_ser #(
    .WORD_W(WORD_W),
    .PAD   (PAD)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (load_go),
    .load    (accept),
    .first   (wcnt == '0),
    .shift   (state == ST_SHIFT),
    .din     (word_in),
    .sout    (cfg_sin),
    .last_bit(last_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      wcnt  <= '0;
      scnt  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == ST_RUN) && (state != ST_RUN);
      if (load_go)
        wcnt <= '0;
      else if (word_end && wcnt != WCW'(NW - 1))
        wcnt <= wcnt + 1'b1;
      scnt <= (state == ST_SETTLE) ? scnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt    = state;
    word_ready   = 1'b0;
    cfg_shift_en = 1'b0;
    cen          = 1'b1;
    reg_ce       = 1'b0;
    busy         = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        word_ready = 1'b1;
        busy       = 1'b1;
        if (word_valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        cfg_shift_en = 1'b1;
        busy         = 1'b1;
        if (last_bit) state_nxt = (wcnt == WCW'(NW - 1)) ? ST_SETTLE : ST_LOAD;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (settle_end) state_nxt = par_ok ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        cen    = 1'b0;
        reg_ce = 1'b1;
        if (start) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef SLICEL_CFG_PARITY_EN
  logic par_acc, par_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc    <= 1'b0;
      par_exp    <= 1'b0;
      parity_err <= 1'b0;
    end else if (load_go) begin
      par_acc    <= 1'b0;
      par_exp    <= cfg_parity;
      parity_err <= 1'b0;
    end else begin
      if (state == ST_SHIFT) par_acc <= par_acc ^ cfg_sin;
      if (settle_end && (par_acc != par_exp)) parity_err <= 1'b1;
    end
  end

  assign par_ok = (par_acc == par_exp);
`else
  assign par_ok = 1'b1;
`endif

endmodule
